// File: rtl/alu_pkg.sv
// Shared definitions for the datapath ALU: default width and operation encodings.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor shared by ADD, SUB and both compares.
// Subtraction is A + ~B + 1, so carry-out is the "no borrow" indicator.
module alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_full;

  assign w_b    = i_sub ? ~i_b : i_b;
  assign w_full = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_sub};
  assign o_sum  = w_full[WIDTH-1:0];
  assign o_cout = w_full[WIDTH];

  // Same-sign addends producing a different-sign sum; covers SUB via the inverted B.
  assign o_ovf = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Integer ALU: operation mux over the shared adder plus a one-cycle output register.
// ans always carries the wrapped result; overflow is only meaningful for ADD/SUB.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] _inum1,
  input  logic [WIDTH-1:0] _inum2,
  output logic [WIDTH-1:0] ans,
  output logic             overflow
);

  logic             w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_as_ovf;
  logic [WIDTH-1:0] w_ans;
  logic             w_ovf;
  logic [WIDTH-1:0] r_ans;
  logic             r_ovf;

  assign w_sub = (ctrl != ALU_ADD);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a    (_inum1),
    .i_b    (_inum2),
    .i_sub  (w_sub),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_ovf  (w_as_ovf)
  );

  // Next-state result select; SLT corrects the sign of A-B when the subtraction overflows.
  always_comb begin
    w_ans = {WIDTH{1'b0}};
    w_ovf = 1'b0;
    case (ctrl)
      ALU_AND:  w_ans = _inum1 & _inum2;
      ALU_OR:   w_ans = _inum1 | _inum2;
      ALU_ADD: begin
        w_ans = w_sum;
        w_ovf = w_as_ovf;
      end
      ALU_XOR:  w_ans = _inum1 ^ _inum2;
      ALU_SUB: begin
        w_ans = w_sum;
        w_ovf = w_as_ovf;
      end
      ALU_NOR:  w_ans = ~(_inum1 | _inum2);
      ALU_SLT:  w_ans = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_as_ovf};
      ALU_SLTU: w_ans = {{(WIDTH-1){1'b0}}, ~w_cout};
      default: begin
        w_ans = {WIDTH{1'b0}};
        w_ovf = 1'b0;
      end
    endcase
  end

  // Output register with synchronous reset taking priority over the op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ans <= {WIDTH{1'b0}};
      r_ovf <= 1'b0;
    end else begin
      r_ans <= w_ans;
      r_ovf <= w_ovf;
    end
  end

  assign ans      = r_ans;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes reference-model results, monitor pops and compares
// one clock after each issued op.
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] ans;
    logic        ovf;
    string       tag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [2:0]  ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] ans;
  logic        overflow;

  exp_t q[$];
  int   n_checks;
  int   n_fail;

  alu #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .ctrl     (ctrl),
    ._inum1   (a),
    ._inum2   (b),
    .ans      (ans),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: signed/unsigned arithmetic on 64-bit integers, then wrap.
  function automatic exp_t model(input logic r, input logic [2:0] c,
                                 input logic [31:0] x, input logic [31:0] y,
                                 input string tag);
    exp_t   e;
    longint sx;
    longint sy;
    longint ux;
    longint uy;
    longint full;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    e.ans = 32'd0;
    e.ovf = 1'b0;
    e.tag = tag;
    case (c)
      3'd0: e.ans = x & y;
      3'd1: e.ans = x | y;
      3'd2: begin
        full  = sx + sy;
        e.ans = full[31:0];
        e.ovf = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      3'd3: e.ans = x ^ y;
      3'd4: begin
        full  = sx - sy;
        e.ans = full[31:0];
        e.ovf = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      3'd5: e.ans = ~(x | y);
      3'd6: e.ans = (sx < sy) ? 32'd1 : 32'd0;
      default: e.ans = (ux < uy) ? 32'd1 : 32'd0;
    endcase
    if (r) begin
      e.ans = 32'd0;
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  task automatic issue(input logic r, input logic [2:0] c,
                       input logic [31:0] x, input logic [31:0] y, input string tag);
    @(negedge clk);
    rst  = r;
    ctrl = c;
    a    = x;
    b    = y;
    q.push_back(model(r, c, x, y, tag));
  endtask

  task automatic issue_chk(input logic r, input logic [2:0] c,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] want_ans, input logic want_ovf,
                           input string tag);
    exp_t e;
    e = model(r, c, x, y, tag);
    n_checks++;
    if (e.ans !== want_ans || e.ovf !== want_ovf) begin
      n_fail++;
      $display("FAIL model_%s: model ans=%h ovf=%b, required ans=%h ovf=%b",
               tag, e.ans, e.ovf, want_ans, want_ovf);
    end
    issue(r, c, x, y, tag);
  endtask

  // Monitor: the op driven before this edge must be visible just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (ans !== e.ans || overflow !== e.ovf) begin
          n_fail++;
          $display("FAIL %s: got ans=%h ovf=%b, expected ans=%h ovf=%b",
                   e.tag, ans, overflow, e.ans, e.ovf);
        end
      end
    end
  end

  initial begin
    logic [31:0] edges [6];
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  c;
    edges = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF,
              32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    ctrl = ALU_ADD;
    a    = 32'd0;
    b    = 32'd0;

    issue(1'b1, ALU_ADD, 32'd0, 32'd0, "por0");
    issue(1'b1, ALU_NOR, 32'd0, 32'd0, "por1");

    issue_chk(1'b0, ALU_ADD, 32'd35, 32'd20, 32'd55, 1'b0, "add_basic");
    issue_chk(1'b0, ALU_SUB, 32'd35, 32'd20, 32'd15, 1'b0, "sub_basic");
    issue_chk(1'b0, ALU_OR,  32'd35, 32'd20, 32'd55, 1'b0, "or_basic");
    issue_chk(1'b0, ALU_AND, 32'd35, 32'd20, 32'd0,  1'b0, "and_basic");

    issue_chk(1'b0, ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, "add_ovf");
    issue_chk(1'b0, ALU_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, "sub_ovf");
    issue_chk(1'b0, ALU_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, "add_wrap");
    issue_chk(1'b0, ALU_SUB, 32'h0000_0001, 32'h8000_0000, 32'h8000_0001, 1'b1, "sub_ovf_pos");

    issue_chk(1'b0, ALU_SLT,  32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, "slt_neg");
    issue_chk(1'b0, ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, "sltu_big");
    issue_chk(1'b0, ALU_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1'b0, "slt_ovfcorr");
    issue_chk(1'b0, ALU_SLT,  32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, "slt_ovfcorr2");
    issue_chk(1'b0, ALU_SLTU, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b0, "sltu_small");
    issue_chk(1'b0, ALU_SLT,  32'd5, 32'd5, 32'h0, 1'b0, "slt_equal");

    issue_chk(1'b0, ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, "xor");
    issue_chk(1'b0, ALU_NOR, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, "nor_zero");

    issue_chk(1'b1, ALU_ADD, 32'd35, 32'd20, 32'd0,  1'b0, "rst_mid");
    issue_chk(1'b0, ALU_ADD, 32'd35, 32'd20, 32'd55, 1'b0, "after_rst");
    issue_chk(1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'd0, 1'b0, "rst_over_ovf");

    for (int i = 0; i < 400; i++) begin
      x = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom();
      y = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom();
      c = (i < 200) ? 3'(i % 8) : 3'($urandom_range(0, 7));
      issue(1'b0, c, x, y, "random");
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending results, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the single-cycle CPU datapath.
- Takes two operands and a 3-bit operation code, computes the result, and reports signed overflow for add/subtract.
- Result and flag are registered, giving a 1-cycle latency. Fed by the ALU-control decoder; drives writeback and branch-compare logic.

Parameters:
- WIDTH, 32, operand/result width in bits (all behaviour below stated for 32; must scale).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ctrl  input  3  operation select (encoding below).
- _inum1  input  WIDTH  operand A.
- _inum2  input  WIDTH  operand B.
- ans  output  WIDTH  registered result.
- overflow  output  1  registered signed-overflow flag.

Behaviour:
- Reset, synchronous and active-high: on the rising clk edge with rst=1, ans<=0 and overflow<=0. rst has priority over any operation.
- Latency: inputs sampled at rising edge N; ans/overflow valid after edge N. Exactly 1 cycle, fully pipelined, new op every cycle, no handshake.
- Outputs hold their value between edges. No combinational path from inputs to outputs.
- ctrl encoding (A=_inum1, B=_inum2):
  - 000 AND: A & B.
  - 001 OR: A | B.
  - 010 ADD: A + B mod 2^32.
  - 011 XOR: A ^ B.
  - 100 SUB: A - B mod 2^32.
  - 101 NOR: ~(A | B).
  - 110 SLT: 1 if signed A < signed B, else 0 (zero-extended).
  - 111 SLTU: 1 if unsigned A < unsigned B, else 0.
- Overflow, two's-complement:
  - ADD: set when A and B have the same sign and the result sign differs.
  - SUB: set when A and B differ in sign and the result sign differs from A.
  - All other ops: overflow=0.
- ans is always written with the wrapped result, even when overflow=1. Trapping is the caller's job.
- SLT must be correct when A-B overflows: use sign(A-B) XOR overflow(A-B).
- Unknown/X on ctrl: no special handling required. The case statement has a default of ans=0, overflow=0.
- Reset asserted mid-stream: the next edge clears outputs; the op presented on that edge is discarded.

Decomposition:
- Shared package alu_pkg holds:
  - localparams ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_XOR=3'b011, ALU_SUB=3'b100, ALU_NOR=3'b101, ALU_SLT=3'b110, ALU_SLTU=3'b111;
  - the WIDTH default.
- One sub-module, alu_addsub: a combinational WIDTH-bit adder/subtractor with sub input. It outputs sum, carry-out and signed overflow, and is shared by ADD/SUB/SLT/SLTU (SLTU = NOT carry-out of A-B).
- Top-level alu contains the op mux and the output register.

Test Plan:
- Basic ops, A=35, B=20, one op per cycle, each checked 1 cycle later:
  - ctrl=010 -> ans=55, ovf=0.
  - ctrl=100 -> ans=15, ovf=0.
  - ctrl=001 -> ans=55.
  - ctrl=000 -> ans=0.
- Overflow:
  - ADD 0x7FFFFFFF+0x00000001 -> ans=0x80000000, ovf=1.
  - SUB 0x80000000-0x00000001 -> ans=0x7FFFFFFF, ovf=1.
  - ADD 0xFFFFFFFF+0x00000001 -> ans=0, ovf=0.
- Compare:
  - SLT A=0xFFFFFFFF, B=1 -> ans=1; SLTU same operands -> ans=0.
  - SLT A=0x80000000, B=0x7FFFFFFF -> ans=1 (overflow-corrected).
- Logic:
  - XOR 0xF0F0F0F0^0xFF00FF00 -> 0x0FF00FF0.
  - NOR 0,0 -> 0xFFFFFFFF, ovf=0.
- Reset: assert rst for one edge while ctrl=010, A=35, B=20 -> ans=0, ovf=0 after that edge. Deassert -> ans=55 one edge later. Outputs are 0 after power-on reset before any op.
- Back-to-back: change ctrl every cycle through all 8 codes with random operands -> each result appears exactly 1 cycle after its inputs, matching a reference model.
